dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 7 +
 rtl/dmem_rr_pick.sv | 11 +
 rtl/dmem_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding, owner IDs and field widths for dmem_arbiter.
package dmem_arb_pkg;
  localparam int F3W = 3;
  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DMA = 1'b1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-way winner select; on a tie the requester that did not win last time wins.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic c_req,
  input  logic d_req,
  input  logic last_owner,
  output logic winner
);
  assign winner = (c_req && d_req) ? ~last_owner : (c_req ? OWN_CORE : OWN_DMA);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory port between the core and a DMA/loader, IDLE->ACCESS->RESP.
// DMEM_ARB_FIXED_PRIO_EN: core always wins ties and no last_owner pointer is kept.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               c_req,
  input  logic               c_we,
  input  logic [F3W-1:0]     c_funct3,
  input  logic [BITSIZE-1:0] c_addr,
  input  logic [BITSIZE-1:0] c_wdata,
  output logic               c_gnt,
  output logic               c_rvalid,
  output logic [BITSIZE-1:0] c_rdata,
  output logic               c_stall,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [F3W-1:0]     d_funct3,
  input  logic [BITSIZE-1:0] d_addr,
  input  logic [BITSIZE-1:0] d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [BITSIZE-1:0] d_rdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [F3W-1:0]     mem_funct3,
  output logic [BITSIZE-1:0] mem_addr,
  output logic [BITSIZE-1:0] mem_wdata,
  input  logic [BITSIZE-1:0] mem_rdata
);
  state_t state;
  logic owner, we_q, last_owner, winner, grant, access, resp;
  logic [F3W-1:0] funct3_q;
  logic [BITSIZE-1:0] addr_q, wdata_q, rdata_q, rsp_data;
  dmem_rr_pick u_pick (
    .c_req(c_req),
    .d_req(d_req),
    .last_owner(last_owner),
    .winner(winner)
  );
`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign last_owner = OWN_DMA;
`endif
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      owner <= OWN_CORE;
      we_q <= 1'b0;
      funct3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_owner <= OWN_DMA;
`endif
    end else begin
      case (state)
        IDLE: if (c_req || d_req) begin
          state <= ACCESS;
          owner <= winner;
          we_q <= (winner == OWN_DMA) ? d_we : c_we;
          funct3_q <= (winner == OWN_DMA) ? d_funct3 : c_funct3;
          addr_q <= (winner == OWN_DMA) ? d_addr : c_addr;
          wdata_q <= (winner == OWN_DMA) ? d_wdata : c_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last_owner <= winner;
`endif
        end
        ACCESS: begin
          state <= RESP;
          if (!we_q) rdata_q <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Grants are held off while reset is low so a requester never sees a grant that gets discarded.
  assign grant = (state == IDLE) && reset && (c_req || d_req);
  assign access = state == ACCESS;
  assign resp = state == RESP;
  assign c_gnt = grant && (winner == OWN_CORE);
  assign d_gnt = grant && (winner == OWN_DMA);
  assign mem_read = access && !we_q;
  assign mem_write = access && we_q && reset;
  assign mem_funct3 = access ? funct3_q : '0;
  assign mem_addr = access ? addr_q : '0;
  assign mem_wdata = access ? wdata_q : '0;
  assign rsp_data = we_q ? '0 : rdata_q;
  assign c_rvalid = resp && (owner == OWN_CORE);
  assign d_rvalid = resp && (owner == OWN_DMA);
  assign c_rdata = c_rvalid ? rsp_data : '0;
  assign d_rdata = d_rvalid ? rsp_data : '0;
  assign c_stall = c_req && !c_rvalid;
endmodule
